// File: rtl/player_plot_sched.sv
// Round-robin plot scheduler for N players feeding vga_adapter, with a
// full-screen background clear sweep. Optional macro PLOT_BORDER_CLIP_EN
// rejects position updates that fall outside the visible screen.
//
// state  | meaning
// -------+-----------------------------------------------------------
// RUN    | grant one pending player per cycle, round-robin from rr
// CLEAR  | sweep every pixel with BG_COLOUR, y outer / x inner
module player_plot_sched #(
    parameter int NUM_PLAYERS = 4,
    parameter int XW          = 8,
    parameter int YW          = 7,
    parameter int CW          = 3,
    parameter int SCREEN_W    = 160,
    parameter int SCREEN_H    = 120,
    parameter logic [NUM_PLAYERS*CW-1:0] COLOUR_TABLE = 12'b110_100_010_001,
    parameter logic [CW-1:0]             BG_COLOUR    = 3'b000
) (
    input  logic                          CLOCK_50,
    input  logic                          resetn,
    input  logic                          clear_req,
    input  logic [NUM_PLAYERS*(XW+YW)-1:0] pos_in,
    input  logic [NUM_PLAYERS-1:0]        pos_valid,
    output logic [XW-1:0]                 x,
    output logic [YW-1:0]                 y,
    output logic [CW-1:0]                 colour,
    output logic                          plot,
    output logic                          busy,
    output logic [NUM_PLAYERS-1:0]        pending,
    output logic [NUM_PLAYERS-1:0]        overrun,
    output logic [NUM_PLAYERS-1:0]        clipped
);
    localparam int PW = XW + YW;
    localparam int RW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;

    typedef enum logic {ST_RUN, ST_CLEAR} state_t;

    state_t                    state_q, state_d;
    logic [RW-1:0]             rr_q, rr_d;
    logic [NUM_PLAYERS-1:0]    pend_q, pend_d;
    logic [NUM_PLAYERS-1:0]    ovr_q, ovr_d;
    logic [NUM_PLAYERS-1:0]    clip_q, clip_d;
    logic [NUM_PLAYERS*PW-1:0] pos_q, pos_d;
    logic [XW-1:0]             x_q, x_d, cx_q, cx_d;
    logic [YW-1:0]             y_q, y_d, cy_q, cy_d;
    logic [CW-1:0]             col_q, col_d;
    logic                      plot_q, plot_d;

    logic                      gnt_vld;
    logic [RW-1:0]             gnt_idx;
    logic                      gnt_taken;
    int                        scan_idx;
    logic [NUM_PLAYERS-1:0]    accept;

    // First pending player at or after rr, wrapping around.
    always_comb begin
        gnt_vld  = 1'b0;
        gnt_idx  = '0;
        scan_idx = 0;
        for (int k = 0; k < NUM_PLAYERS; k++) begin
            scan_idx = int'(rr_q) + k;
            if (scan_idx >= NUM_PLAYERS) scan_idx = scan_idx - NUM_PLAYERS;
            if (!gnt_vld && pend_q[scan_idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = RW'(scan_idx);
            end
        end
    end

    // Decide which strobed updates are latched; off-screen ones are dropped when clipping.
    always_comb begin
        accept = pos_valid;
        clip_d = '0;
`ifdef PLOT_BORDER_CLIP_EN
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (int'(pos_in[i*PW+YW +: XW]) >= SCREEN_W ||
                int'(pos_in[i*PW +: YW]) >= SCREEN_H) begin
                accept[i] = 1'b0;
                clip_d[i] = pos_valid[i];
            end
        end
`endif
    end

    // Next-state: clear request wins, then the sweep, then a player grant.
    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        pend_d    = pend_q;
        ovr_d     = ovr_q;
        pos_d     = pos_q;
        x_d       = x_q;
        y_d       = y_q;
        col_d     = col_q;
        plot_d    = 1'b0;
        cx_d      = cx_q;
        cy_d      = cy_q;
        gnt_taken = 1'b0;

        if (clear_req) begin
            state_d = ST_CLEAR;
            cx_d    = '0;
            cy_d    = '0;
            pend_d  = '0;
            ovr_d   = '0;
        end else if (state_q == ST_CLEAR) begin
            plot_d = 1'b1;
            x_d    = cx_q;
            y_d    = cy_q;
            col_d  = BG_COLOUR;
            if (cx_q == XW'(SCREEN_W - 1)) begin
                cx_d = '0;
                if (cy_q == YW'(SCREEN_H - 1)) begin
                    cy_d    = '0;
                    state_d = ST_RUN;
                end else begin
                    cy_d = cy_q + 1'b1;
                end
            end else begin
                cx_d = cx_q + 1'b1;
            end
        end else if (gnt_vld) begin
            gnt_taken        = 1'b1;
            plot_d           = 1'b1;
            x_d              = pos_q[int'(gnt_idx)*PW+YW +: XW];
            y_d              = pos_q[int'(gnt_idx)*PW +: YW];
            col_d            = COLOUR_TABLE[int'(gnt_idx)*CW +: CW];
            pend_d[gnt_idx]  = 1'b0;
            if (int'(gnt_idx) == NUM_PLAYERS - 1) rr_d = '0;
            else                                  rr_d = gnt_idx + 1'b1;
        end

        // A granted player's old position has already been read above, so a
        // same-cycle update simply re-arms it without counting as an overrun.
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (accept[i]) begin
                pos_d[i*PW +: PW] = pos_in[i*PW +: PW];
                if (!clear_req && pend_q[i] && !(gnt_taken && int'(gnt_idx) == i))
                    ovr_d[i] = 1'b1;
                pend_d[i] = 1'b1;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_RUN;
            rr_q    <= '0;
            pend_q  <= '0;
            ovr_q   <= '0;
            clip_q  <= '0;
            pos_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            col_q   <= '0;
            plot_q  <= 1'b0;
            cx_q    <= '0;
            cy_q    <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            pend_q  <= pend_d;
            ovr_q   <= ovr_d;
            clip_q  <= clip_d;
            pos_q   <= pos_d;
            x_q     <= x_d;
            y_q     <= y_d;
            col_q   <= col_d;
            plot_q  <= plot_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
        end
    end

    assign x       = x_q;
    assign y       = y_q;
    assign colour  = col_q;
    assign plot    = plot_q;
    assign busy    = (state_q == ST_CLEAR);
    assign pending = pend_q;
    assign overrun = ovr_q;
    assign clipped = clip_q;

endmodule

// File: tb/tb_player_plot_sched.sv
// Scoreboard bench for player_plot_sched: expected plots are queued as the
// stimulus is issued and a forked monitor compares every plot cycle.
module tb_player_plot_sched;
    localparam int N  = 4;
    localparam int XW = 8;
    localparam int YW = 7;
    localparam int CW = 3;
    localparam int PW = XW + YW;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              clear_req = 1'b0;
    logic [N*PW-1:0]   pos_in = '0;
    logic [N-1:0]      pos_valid = '0;
    logic [XW-1:0]     x;
    logic [YW-1:0]     y;
    logic [CW-1:0]     colour;
    logic              plot;
    logic              busy;
    logic [N-1:0]      pending;
    logic [N-1:0]      overrun;
    logic [N-1:0]      clipped;

    typedef struct packed {
        logic [XW-1:0] px;
        logic [YW-1:0] py;
        logic [CW-1:0] pc;
    } plot_t;

    plot_t sb[$];
    int    nchk = 0;
    int    nfail = 0;
    int    npop = 0;
    int    base;
    logic [CW-1:0] pcol [N];

    always #5 clk = ~clk;

    player_plot_sched dut (
        .CLOCK_50 (clk),
        .resetn   (rst_n),
        .clear_req(clear_req),
        .pos_in   (pos_in),
        .pos_valid(pos_valid),
        .x        (x),
        .y        (y),
        .colour   (colour),
        .plot     (plot),
        .busy     (busy),
        .pending  (pending),
        .overrun  (overrun),
        .clipped  (clipped)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        plot_t e;
        forever begin
            @(negedge clk);
            if (plot !== 1'b0) begin
                if (sb.size() == 0) begin
                    nchk++;
                    nfail++;
                    $display("FAIL unexpected_plot actual=(%0d,%0d,%0h) required=no plot", x, y, colour);
                end else begin
                    e = sb.pop_front();
                    chk("plot_xyc", {14'b0, x, y, colour}, {14'b0, e});
                    npop++;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pos(input int i, input int px, input int py);
        pos_in[i*PW +: PW] = {XW'(px), YW'(py)};
    endtask

    task automatic expect_plot(input int px, input int py, input logic [CW-1:0] c);
        sb.push_back({XW'(px), YW'(py), c});
    endtask

    task automatic push_sweep();
        for (int yy = 0; yy < 120; yy++)
            for (int xx = 0; xx < 160; xx++)
                expect_plot(xx, yy, 3'b000);
    endtask

    task automatic wait_empty(input int max_cyc, input string name);
        for (int c = 0; c < max_cyc && sb.size() != 0; c++) tick();
        chk(name, sb.size(), 0);
    endtask

    task automatic wait_pops(input int n, input int max_cyc, input string name);
        base = npop;
        for (int c = 0; c < max_cyc && (npop - base) < n; c++) tick();
        chk(name, npop - base, n);
    endtask

    initial begin
        pcol[0] = 3'b001; pcol[1] = 3'b010; pcol[2] = 3'b100; pcol[3] = 3'b110;
        fork monitor(); join_none

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outputs", {x, y, colour, plot, busy, pending, overrun, clipped}, 0);
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            chk("idle_plot", plot, 0);
            chk("idle_busy", busy, 0);
            chk("idle_pending", pending, 0);
        end

        // all four players strobed together: four consecutive plots
        for (int i = 0; i < N; i++) begin
            set_pos(i, 10 + i, 20 + i);
            expect_plot(10 + i, 20 + i, pcol[i]);
        end
        pos_valid = 4'b1111;
        tick();
        pos_valid = '0;
        chk("all_pending", pending, 4'b1111);
        chk("latency_no_plot", plot, 0);
        wait_empty(20, "all4_drain");
        tick();
        chk("all4_pending_clear", pending, 0);
        chk("all4_no_overrun", overrun, 0);

        // P2 overwritten while P1 is granted first
        set_pos(0, 30, 40);
        set_pos(1, 31, 41);
        pos_valid = 4'b0011;
        expect_plot(30, 40, pcol[0]);
        tick();
        set_pos(1, 50, 60);
        pos_valid = 4'b0010;
        expect_plot(50, 60, pcol[1]);
        tick();
        pos_valid = '0;
        chk("overrun_set", overrun, 4'b0010);
        wait_empty(20, "overrun_drain");
        tick();
        chk("overrun_sticky", overrun, 4'b0010);
        chk("overrun_pending", pending, 0);

        // full clear sweep with a P3 update arriving mid-sweep
        push_sweep();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        chk("clear_busy", busy, 1);
        chk("clear_overrun_cleared", overrun, 0);
        repeat (500) tick();
        set_pos(2, 70, 80);
        pos_valid = 4'b0100;
        expect_plot(70, 80, pcol[2]);
        tick();
        pos_valid = '0;
        chk("sweep_p3_pending", pending, 4'b0100);
        chk("sweep_busy_mid", busy, 1);
        wait_empty(25000, "sweep_drain");
        chk("sweep_done_busy", busy, 0);
        chk("sweep_done_pending", pending, 0);

        // restart at pixel 5000
        push_sweep();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        wait_pops(5000, 6000, "reach_pixel_5000");
        while (sb.size() > 1) void'(sb.pop_back());
        push_sweep();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        chk("restart_busy", busy, 1);
        wait_pops(301, 1000, "restart_progress");

        // asynchronous reset mid-sweep
        rst_n = 1'b0;
        #1;
        chk("midsweep_rst", {x, y, colour, plot, busy, pending, overrun, clipped}, 0);
        sb.delete();
        tick();
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("post_rst_busy", busy, 0);
        end

        // P4 off-screen at x=200
        set_pos(3, 200, 5);
        pos_valid = 4'b1000;
`ifdef PLOT_BORDER_CLIP_EN
        tick();
        pos_valid = '0;
        chk("clip_pulse", clipped, 4'b1000);
        chk("clip_no_pending", pending, 0);
        tick();
        chk("clip_pulse_end", clipped, 0);
        repeat (5) tick();
`else
        expect_plot(200, 5, pcol[3]);
        tick();
        pos_valid = '0;
        chk("noclip_pending", pending, 4'b1000);
        chk("noclip_clipped", clipped, 0);
        wait_empty(20, "noclip_drain");
`endif
        tick();
        chk("final_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end
endmodule
